// File: rtl/wptr_full_if.sv
// Write-domain FIFO pointer bus: write request/clear and synchronized read pointer in,
// write address, Gray pointer and status flags out.
interface wptr_full_if #(
  parameter int add_size = 3
);
  logic                wr_inc;
  logic                wr_ovf_clr;
  logic [add_size:0]   rd_ptr_sync;
  logic [add_size-1:0] wr_addr;
  logic [add_size:0]   wr_ptr;
  logic                full;
  logic [add_size:0]   wr_level;
  logic                almost_full;
  logic                overflow;

  modport master (
    output wr_inc, wr_ovf_clr, rd_ptr_sync,
    input  wr_addr, wr_ptr, full, wr_level, almost_full, overflow
  );

  modport slave (
    input  wr_inc, wr_ovf_clr, rd_ptr_sync,
    output wr_addr, wr_ptr, full, wr_level, almost_full, overflow
  );
endinterface

// File: rtl/wptr_full.sv
// Async FIFO write-side pointer, full flag, fill level and sticky overflow (wr_clk domain).
// Optional almost-full comparator enabled by defining WPTR_ALMOST_FULL_EN.
module wptr_full #(
  parameter int add_size  = 3,
  parameter int AF_THRESH = 6
) (
  input logic        wr_clk,
  input logic        wr_rst,
  wptr_full_if.slave bus
);

  if (add_size < 2 || AF_THRESH < 1 || AF_THRESH > (1 << add_size)) begin : g_bad_param
    $error("wptr_full: add_size must be >= 2 and AF_THRESH within 1..2**add_size");
  end

  function automatic logic [add_size:0] gray2bin(input logic [add_size:0] g);
    logic [add_size:0] b;
    b[add_size] = g[add_size];
    for (int i = add_size - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [add_size:0] r_wbin;
  logic [add_size:0] r_wptr;
  logic              r_full;
  logic [add_size:0] r_level;
  logic              r_af;
  logic              r_ovf;

  logic              w_accept;
  logic [add_size:0] w_wbin_next;
  logic [add_size:0] w_wgray_next;
  logic [add_size:0] w_rbin_sync;
  logic [add_size:0] w_full_cmp;
  logic [add_size:0] w_level_next;
  logic              w_full_next;
  logic              w_af_next;

  assign w_accept     = bus.wr_inc & ~r_full;
  assign w_wbin_next  = r_wbin + {{add_size{1'b0}}, w_accept};
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
  assign w_rbin_sync  = gray2bin(bus.rd_ptr_sync);
  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
  assign w_full_cmp   = {~bus.rd_ptr_sync[add_size:add_size-1], bus.rd_ptr_sync[add_size-2:0]};
  assign w_full_next  = (w_wgray_next == w_full_cmp);
  assign w_level_next = w_wbin_next - w_rbin_sync;

`ifdef WPTR_ALMOST_FULL_EN
  localparam logic [add_size:0] AF_LVL = (add_size+1)'(AF_THRESH);
  assign w_af_next = (w_level_next >= AF_LVL);
`else
  assign w_af_next = 1'b0;
`endif

  // p0: single write-clock register stage for every output
  always_ff @(posedge wr_clk) begin
    if (!wr_rst) begin
      r_wbin  <= '0;
      r_wptr  <= '0;
      r_full  <= 1'b0;
      r_level <= '0;
      r_af    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wptr  <= w_wgray_next;
      r_full  <= w_full_next;
      r_level <= w_level_next;
      r_af    <= w_af_next;
      if (bus.wr_inc && r_full) begin
        r_ovf <= 1'b1;
      end else if (bus.wr_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.wr_addr     = r_wbin[add_size-1:0];
  assign bus.wr_ptr      = r_wptr;
  assign bus.full        = r_full;
  assign bus.wr_level    = r_level;
  assign bus.almost_full = r_af;
  assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full: reset, fill, overflow, release, almost-full and wrap-around.
module tb_wptr_full;

  localparam int AS = 3;
`ifdef WPTR_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic wr_clk = 1'b0;
  logic wr_rst;
  int   n_total = 0;
  int   n_bad   = 0;

  wptr_full_if #(.add_size(AS)) bus ();

  wptr_full #(.add_size(AS), .AF_THRESH(6)) dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [3:0] fill_ptr [8];
  logic [3:0] rb;
  int         lvl;

  initial begin
    fill_ptr = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

    // reset with a write pending
    wr_rst = 1'b0;
    bus.wr_inc = 1'b1;
    bus.wr_ovf_clr = 1'b0;
    bus.rd_ptr_sync = 4'h0;
    tick();
    tick();
    chk("rst_ptr",   32'(bus.wr_ptr), 0);
    chk("rst_addr",  32'(bus.wr_addr), 0);
    chk("rst_full",  32'(bus.full), 0);
    chk("rst_level", 32'(bus.wr_level), 0);
    chk("rst_af",    32'(bus.almost_full), 0);
    chk("rst_ovf",   32'(bus.overflow), 0);

    // fill 8 entries
    wr_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("fill_ptr%0d", i),   32'(bus.wr_ptr), 32'(fill_ptr[i]));
      chk($sformatf("fill_addr%0d", i),  32'(bus.wr_addr), (i + 1) % 8);
      chk($sformatf("fill_level%0d", i), 32'(bus.wr_level), i + 1);
      chk($sformatf("fill_full%0d", i),  32'(bus.full), (i == 7) ? 1 : 0);
      chk($sformatf("fill_af%0d", i),    32'(bus.almost_full), (AF_EN && (i + 1) >= 6) ? 1 : 0);
    end

    // overflow: rejected write, sticky flag, set wins over clear
    tick();
    chk("ovf_ptr",   32'(bus.wr_ptr), 32'hC);
    chk("ovf_level", 32'(bus.wr_level), 8);
    chk("ovf_addr",  32'(bus.wr_addr), 0);
    chk("ovf_full",  32'(bus.full), 1);
    chk("ovf_set",   32'(bus.overflow), 1);
    bus.wr_inc = 1'b0;
    tick();
    chk("ovf_hold",  32'(bus.overflow), 1);
    bus.wr_inc = 1'b1;
    bus.wr_ovf_clr = 1'b1;
    tick();
    chk("ovf_setwins", 32'(bus.overflow), 1);
    bus.wr_inc = 1'b0;
    tick();
    chk("ovf_clr",   32'(bus.overflow), 0);
    bus.wr_ovf_clr = 1'b0;

    // release one entry, then refill
    bus.rd_ptr_sync = 4'h1;
    tick();
    chk("rel_full",  32'(bus.full), 0);
    chk("rel_level", 32'(bus.wr_level), 7);
    chk("rel_af",    32'(bus.almost_full), AF_EN ? 1 : 0);
    bus.wr_inc = 1'b1;
    tick();
    chk("refill_full",  32'(bus.full), 1);
    chk("refill_level", 32'(bus.wr_level), 8);
    chk("refill_ptr",   32'(bus.wr_ptr), 32'hD);
    chk("refill_addr",  32'(bus.wr_addr), 1);
    chk("refill_ovf",   32'(bus.overflow), 0);

    // coherent reset, then wrap with the reader trailing five behind
    wr_rst = 1'b0;
    bus.wr_inc = 1'b0;
    bus.rd_ptr_sync = 4'h0;
    tick();
    wr_rst = 1'b1;
    bus.wr_inc = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      rb = (j >= 5) ? 4'(j - 5) : 4'h0;
      bus.rd_ptr_sync = gray4(rb);
      tick();
      lvl = (j - int'(rb)) & 15;
      chk($sformatf("wrap_ptr%0d", j),   32'(bus.wr_ptr), 32'(gray4(4'(j))));
      chk($sformatf("wrap_addr%0d", j),  32'(bus.wr_addr), j % 8);
      chk($sformatf("wrap_level%0d", j), 32'(bus.wr_level), lvl);
      chk($sformatf("wrap_full%0d", j),  32'(bus.full), 0);
      chk($sformatf("wrap_af%0d", j),    32'(bus.almost_full), 0);
      if (j == 16) chk("wrap_ptr_zero", 32'(bus.wr_ptr), 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
